hazard_monitor: RTL and testbench

Parametrised, clocked successor to the combinational gas/smoke/humidity/temperature hazard indicator. Debounces NUM_SENSORS raw trip inputs, counts the active channels, and drives a latched red/yellow/green indicator from a four-state FSM. Red requires operator acknowledge plus a timed cooldown before it can clear. Sits between the sensor front-ends and the indicator lamps and alarm logic.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_debounce.sv | 35 +++
 rtl/hazard_monitor.sv | 117 +++++++++++
 tb/tb_hazard_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, lamp codes and helpers for the hazard monitor.
package hazard_pkg;

    typedef enum logic [1:0] {
        SAFE     = 2'd0,
        WARN     = 2'd1,
        ALARM    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Lamp vector layout is {red, yellow, green}.
    localparam int unsigned LAMP_W = 3;
    localparam logic [LAMP_W-1:0] LAMP_GREEN  = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_YELLOW = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_RED    = 3'b100;

    // Widest sensor vector the popcount helper accepts.
    localparam int unsigned MAX_SENSORS = 32;

    // Moore lamp decode: exactly one lamp per state.
    function automatic logic [LAMP_W-1:0] lamp_of(input state_t s);
        logic [LAMP_W-1:0] l;
        case (s)
            SAFE:    l = LAMP_GREEN;
            ALARM:   l = LAMP_RED;
            default: l = LAMP_YELLOW;
        endcase
        return l;
    endfunction

    // Number of set bits in a sensor vector.
    function automatic int unsigned popcount(input logic [MAX_SENSORS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MAX_SENSORS); i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hazard_debounce.sv
// Single-channel debounce filter with maintenance mask.
module hazard_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic Iraw,
    input  logic Imask,
    output logic Ofilt
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Toggle the filtered value once the raw input has disagreed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            Ofilt <= 1'b0;
        end else if (Imask) begin
            cnt   <= '0;
            Ofilt <= 1'b0;
        end else if (Iraw == Ofilt) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            Ofilt <= ~Ofilt;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hazard_monitor.sv
// Debounced multi-sensor hazard indicator with acknowledged, timed alarm clear.
module hazard_monitor
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SENSORS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RED_THRESHOLD   = 2,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] Isensor,
    input  logic [NUM_SENSORS-1:0] Imask,
    input  logic                   Iack,
    output logic                   Ored,
    output logic                   Oyellow,
    output logic                   Ogreen,
    output logic [NUM_SENSORS-1:0] Oactive,
    output logic [NUM_SENSORS-1:0] Olatched,
    output logic [1:0]             Ostate
);

    localparam int unsigned CNT_W  = $clog2(NUM_SENSORS + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  RED_CNT   = CNT_W'(RED_THRESHOLD);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    logic [LAMP_W-1:0]   lamp;
    logic [HOLD_W-1:0]   cool;
    logic [CNT_W-1:0]    count_c;

    // One filter per sensor channel.
    for (genvar i = 0; i < int'(NUM_SENSORS); i++) begin : g_chan
        hazard_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .Iraw  (Isensor[i]),
            .Imask (Imask[i]),
            .Ofilt (Oactive[i])
        );
    end

    // Active channel count from the registered filtered flags.
    always_comb begin
        count_c = CNT_W'(popcount(MAX_SENSORS'(Oactive)));
    end

    // Indicator FSM with cooldown timer, latched channel record and registered lamps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SAFE;
            lamp     <= LAMP_GREEN;
            cool     <= '0;
            Olatched <= '0;
        end else begin
            case (state)
                SAFE, WARN: begin
                    if (count_c >= RED_CNT) begin
                        state    <= ALARM;
                        lamp     <= lamp_of(ALARM);
                        Olatched <= Oactive;
                    end else if (count_c != '0) begin
                        state <= WARN;
                        lamp  <= lamp_of(WARN);
                    end else begin
                        state <= SAFE;
                        lamp  <= lamp_of(SAFE);
                    end
                end
                ALARM: begin
                    Olatched <= Olatched | Oactive;
                    // Ack only counts when the hazard has already subsided.
                    if (Iack && (count_c < RED_CNT)) begin
                        state <= COOLDOWN;
                        lamp  <= lamp_of(COOLDOWN);
                        cool  <= HOLD_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (count_c >= RED_CNT) begin
                        state    <= ALARM;
                        lamp     <= lamp_of(ALARM);
                        Olatched <= Olatched | Oactive;
                    end else if (cool == '0) begin
                        Olatched <= '0;
                        if (count_c != '0) begin
                            state <= WARN;
                            lamp  <= lamp_of(WARN);
                        end else begin
                            state <= SAFE;
                            lamp  <= lamp_of(SAFE);
                        end
                    end else begin
                        Olatched <= Olatched | Oactive;
                        cool     <= cool - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= SAFE;
                    lamp  <= LAMP_GREEN;
                end
            endcase
        end
    end

    // Lamps and debug state straight from registers.
    always_comb begin
        Ored    = lamp[2];
        Oyellow = lamp[1];
        Ogreen  = lamp[0];
        Ostate  = state;
    end

endmodule

// File: tb/tb_hazard_monitor.sv
// Directed self-checking bench for hazard_monitor at default parameters.
module tb_hazard_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] sensor;
    logic [3:0] mask;
    logic       ack;
    logic       red;
    logic       yellow;
    logic       green;
    logic [3:0] active;
    logic [3:0] latched;
    logic [1:0] state;
    logic [2:0] lamps;

    int unsigned vectors;
    int unsigned miscompares;

    hazard_monitor #(
        .NUM_SENSORS    (4),
        .DEBOUNCE_CYCLES(4),
        .RED_THRESHOLD  (2),
        .HOLD_CYCLES    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Isensor  (sensor),
        .Imask    (mask),
        .Iack     (ack),
        .Ored     (red),
        .Oyellow  (yellow),
        .Ogreen   (green),
        .Oactive  (active),
        .Olatched (latched),
        .Ostate   (state)
    );

    assign lamps = {red, yellow, green};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        sensor = 4'b0000;
        mask   = 4'b0000;
        ack    = 1'b0;
        tick();
        tick();
        chk("rst_lamps", 32'(lamps), 32'h1);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_latched", 32'(latched), 32'h0);
        rst = 1'b0;

        // Idle: green throughout
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_lamps", 32'(lamps), 32'h1);
            chk("idle_state", 32'(state), 32'h0);
            chk("idle_active", 32'(active), 32'h0);
        end

        // Single temperature channel -> warning
        sensor = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("warn_pre_active", 32'(active), 32'h0);
        end
        tick();
        chk("warn_active", 32'(active), 32'h8);
        chk("warn_lamp_lag", 32'(lamps), 32'h1);
        tick();
        chk("warn_lamps", 32'(lamps), 32'h2);
        chk("warn_state", 32'(state), 32'h1);
        sensor = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("warn_hold_active", 32'(active), 32'h8);
        end
        tick();
        chk("warn_clear_active", 32'(active), 32'h0);
        chk("warn_clear_lag", 32'(lamps), 32'h2);
        tick();
        chk("back_green", 32'(lamps), 32'h1);

        // 3-cycle glitch is filtered out
        sensor = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_active", 32'(active), 32'h0);
        end
        sensor = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_active_after", 32'(active), 32'h0);
            chk("glitch_lamps", 32'(lamps), 32'h1);
        end

        // Two channels -> alarm, early ack discarded
        sensor = 4'b0011;
        for (int i = 0; i < 4; i++) tick();
        chk("alarm_active", 32'(active), 32'h3);
        chk("alarm_lamp_lag", 32'(lamps), 32'h1);
        tick();
        chk("alarm_lamps", 32'(lamps), 32'h4);
        chk("alarm_state", 32'(state), 32'h2);
        chk("alarm_latched", 32'(latched), 32'h3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("early_ack_state", 32'(state), 32'h2);
        tick();
        chk("early_ack_not_queued", 32'(state), 32'h2);
        sensor = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        chk("alarm_drop_active", 32'(active), 32'h0);
        chk("alarm_wait_ack", 32'(state), 32'h2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("cool_state", 32'(state), 32'h3);
        chk("cool_lamps", 32'(lamps), 32'h2);
        chk("cool_latched", 32'(latched), 32'h3);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("cool_hold", 32'(state), 32'h3);
        end
        tick();
        chk("cool_exit_state", 32'(state), 32'h0);
        chk("cool_exit_lamps", 32'(lamps), 32'h1);
        chk("cool_exit_latched", 32'(latched), 32'h0);

        // Re-alarm during cooldown keeps latched record
        sensor = 4'b0011;
        for (int i = 0; i < 5; i++) tick();
        chk("re_alarm_state", 32'(state), 32'h2);
        sensor = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        chk("re_drop_active", 32'(active), 32'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("re_cool_c1", 32'(state), 32'h3);
        tick();
        tick();
        chk("re_cool_c3", 32'(state), 32'h3);
        sensor = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("re_cool_pending", 32'(state), 32'h3);
        end
        tick();
        sensor = 4'b0000;
        chk("re_cool_active", 32'(active), 32'h5);
        chk("re_cool_latched", 32'(latched), 32'h3);
        tick();
        chk("realarm_state", 32'(state), 32'h2);
        chk("realarm_lamps", 32'(lamps), 32'h4);
        chk("realarm_latched", 32'(latched), 32'h7);

        // Reset mid-alarm, mid-debounce
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_lamps", 32'(lamps), 32'h1);
        chk("mid_rst_state", 32'(state), 32'h0);
        chk("mid_rst_active", 32'(active), 32'h0);
        chk("mid_rst_latched", 32'(latched), 32'h0);

        // Reset clears a partly counted debounce
        sensor = 4'b1000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("db_rst_active", 32'(active), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("db_rst_recount", 32'(active), 32'h0);
        end
        tick();
        chk("db_rst_rise", 32'(active), 32'h8);
        sensor = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Masked channels never contribute
        sensor = 4'b1111;
        mask   = 4'b1110;
        for (int i = 0; i < 3; i++) tick();
        chk("mask_pre_active", 32'(active), 32'h0);
        tick();
        chk("mask_active", 32'(active), 32'h1);
        tick();
        chk("mask_lamps", 32'(lamps), 32'h2);
        chk("mask_state", 32'(state), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mask_no_red", 32'(lamps), 32'h2);
            chk("mask_hold_active", 32'(active), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
